// File: rtl/vga_frame_ctrl_if.sv
// vga_frame_ctrl_if: pixel position, config handshake and display outputs of the frame controller
interface vga_frame_ctrl_if;
   logic [9:0]  p_x;
   logic [9:0]  p_y;
   logic        v_ON;
   logic        cfg_valid;
   logic [1:0]  cfg_mode;
   logic [11:0] cfg_color;
   logic        cfg_ready;
   logic        cfg_pending;
   logic [1:0]  mode_q;
   logic [7:0]  frame_cnt;
   logic [11:0] rgb_out;
   modport master (output p_x, p_y, v_ON, cfg_valid, cfg_mode, cfg_color,
                   input cfg_ready, cfg_pending, mode_q, frame_cnt, rgb_out);
   modport slave  (input p_x, p_y, v_ON, cfg_valid, cfg_mode, cfg_color,
                   output cfg_ready, cfg_pending, mode_q, frame_cnt, rgb_out);
endinterface

// File: rtl/vga_frame_ctrl.sv
// vga_frame_ctrl: owns display config, commits it only in vblank, drives registered pixel colour
module vga_frame_ctrl #(
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int BAR_W     = 80,
   parameter int CHK_LOG2  = 5,
   parameter int BLINK_BIT = 4
) (
   input logic             clk,
   input logic             rst,
   vga_frame_ctrl_if.slave bus
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_PEND   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;
   localparam logic [9:0] V_END    = 10'(V_ACTIVE);
   localparam logic [9:0] H_END    = 10'(H_ACTIVE);
   localparam logic [9:0] BAR_W10  = 10'(BAR_W);
   localparam logic [9:0] BAR_END  = 10'(7 * BAR_W);
   localparam logic [11:0] BAR_TBL [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                           12'hF0F, 12'hF00, 12'h00F, 12'h000};
   logic [1:0]  r_state;
   logic [1:0]  r_sh_mode;
   logic [11:0] r_sh_color;
   logic [1:0]  r_mode;
   logic [11:0] r_color;
   logic [7:0]  r_fcnt;
   logic        r_vb;
   logic [11:0] r_rgb;
   logic        w_vblank;
   logic [2:0]  w_idx;
   logic [11:0] w_pix;
   assign w_vblank = bus.p_y >= V_END;
   // columns past the last bar (or past the visible width) fall into the black bar
   assign w_idx = (bus.p_x >= BAR_END || bus.p_x >= H_END) ? 3'd7 : 3'(bus.p_x / BAR_W10);
   assign w_pix = (r_mode == 2'd0) ? r_color :
                  (r_mode == 2'd1) ? BAR_TBL[w_idx] :
                  (r_mode == 2'd2) ? ((bus.p_x[CHK_LOG2] ^ bus.p_y[CHK_LOG2]) ? 12'h000 : r_color) :
                  (r_fcnt[BLINK_BIT] ? 12'h000 : r_color);
   assign bus.cfg_ready   = r_state == S_IDLE;
   assign bus.cfg_pending = r_state != S_IDLE;
   assign bus.mode_q      = r_mode;
   assign bus.frame_cnt   = r_fcnt;
   assign bus.rgb_out     = r_rgb;
   // config handshake: capture in IDLE, hold until vblank, commit on the edge leaving COMMIT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_sh_mode  <= 2'd0;
         r_sh_color <= 12'h000;
         r_mode     <= 2'd0;
         r_color    <= 12'h000;
      end else begin
         case (r_state)
            S_IDLE: if (bus.cfg_valid) begin
               r_sh_mode  <= bus.cfg_mode;
               r_sh_color <= bus.cfg_color;
               r_state    <= S_PEND;
            end
            S_PEND: if (w_vblank) r_state <= S_COMMIT;
            S_COMMIT: begin
               r_mode  <= r_sh_mode;
               r_color <= r_sh_color;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
   // frame counter steps on each vblank rising edge, independent of the handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vb   <= 1'b1;
         r_fcnt <= 8'd0;
      end else begin
         r_vb <= w_vblank;
         if (w_vblank && !r_vb) r_fcnt <= r_fcnt + 8'd1;
      end
   end
   // registered pixel output, blanked outside the visible region
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_rgb <= 12'h000;
      else     r_rgb <= bus.v_ON ? w_pix : 12'h000;
   end
endmodule

// File: tb/tb_vga_frame_ctrl.sv
// tb_vga_frame_ctrl: directed checks of commit timing, pattern modes, backpressure, frame counter and reset
module tb_vga_frame_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   fc    = 0;

   always #5 clk = ~clk;

   vga_frame_ctrl_if bus();
   vga_frame_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic goto_vb();
      if (bus.p_y < 10'd480) fc++;
      bus.p_y  = 10'd480;
      bus.v_ON = 1'b0;
   endtask

   task automatic goto_vis();
      bus.p_y  = 10'd0;
      bus.v_ON = 1'b1;
   endtask

   task automatic pix(input int x, input int y, input logic von, input logic [11:0] exp, input string tag);
      bus.p_x  = 10'(x);
      bus.p_y  = 10'(y);
      bus.v_ON = von;
      tick();
      chk(tag, bus.rgb_out, exp);
   endtask

   task automatic frame();
      goto_vb();
      tick();
      goto_vis();
      tick();
   endtask

   task automatic apply_cfg(input logic [1:0] m, input logic [11:0] c);
      bus.cfg_valid = 1'b1;
      bus.cfg_mode  = m;
      bus.cfg_color = c;
      goto_vb();
      tick();
      bus.cfg_valid = 1'b0;
      chk("cfg_ready_low", bus.cfg_ready, 0);
      chk("cfg_pending_high", bus.cfg_pending, 1);
      tick(2);
      chk("cfg_mode_live", bus.mode_q, m);
      chk("cfg_ready_back", bus.cfg_ready, 1);
      goto_vis();
   endtask

   initial begin
      rst = 1'b1;
      bus.p_x = 10'd10;
      bus.p_y = 10'd10;
      bus.v_ON = 1'b1;
      bus.cfg_valid = 1'b0;
      bus.cfg_mode = 2'd0;
      bus.cfg_color = 12'h000;
      tick(2);
      chk("rst_rgb", bus.rgb_out, 0);
      chk("rst_ready", bus.cfg_ready, 1);
      chk("rst_pending", bus.cfg_pending, 0);
      chk("rst_fcnt", bus.frame_cnt, 0);
      chk("rst_mode", bus.mode_q, 0);
      rst = 1'b0;
      tick();
      // commit timing: capture in visible region waits for vblank
      bus.p_y = 10'd100;
      bus.cfg_valid = 1'b1;
      bus.cfg_mode = 2'd0;
      bus.cfg_color = 12'hF00;
      tick();
      bus.cfg_valid = 1'b0;
      chk("t2_ready", bus.cfg_ready, 0);
      chk("t2_pending", bus.cfg_pending, 1);
      chk("t2_rgb_old", bus.rgb_out, 12'h000);
      tick(3);
      chk("t2_still_pending", bus.cfg_pending, 1);
      chk("t2_rgb_wait", bus.rgb_out, 12'h000);
      goto_vb();
      tick();
      chk("t2_commit_state", bus.cfg_pending, 1);
      tick();
      chk("t2_ready_back", bus.cfg_ready, 1);
      chk("t2_pending_clr", bus.cfg_pending, 0);
      chk("t2_fcnt", bus.frame_cnt, 1);
      chk("t2_rgb_blank", bus.rgb_out, 12'h000);
      pix(5, 0, 1'b1, 12'hF00, "t2_rgb_new");
      // colour bars
      apply_cfg(2'd1, 12'h123);
      pix(79, 0, 1'b1, 12'hFFF, "bar_79");
      pix(80, 0, 1'b1, 12'hFF0, "bar_80");
      pix(300, 0, 1'b1, 12'h0F0, "bar_300");
      pix(480, 0, 1'b1, 12'h00F, "bar_480");
      pix(639, 0, 1'b1, 12'h000, "bar_639");
      pix(100, 0, 1'b0, 12'h000, "bar_blank");
      // checker
      apply_cfg(2'd2, 12'h0F0);
      pix(31, 0, 1'b1, 12'h0F0, "chk_31_0");
      pix(32, 0, 1'b1, 12'h000, "chk_32_0");
      pix(32, 32, 1'b1, 12'h0F0, "chk_32_32");
      pix(0, 32, 1'b1, 12'h000, "chk_0_32");
      // backpressure: second request while pending is ignored
      bus.p_y = 10'd100;
      bus.cfg_valid = 1'b1;
      bus.cfg_mode = 2'd0;
      bus.cfg_color = 12'h00F;
      tick();
      bus.cfg_mode = 2'd3;
      bus.cfg_color = 12'hFFF;
      tick(3);
      chk("bp_ready", bus.cfg_ready, 0);
      chk("bp_mode_old", bus.mode_q, 2);
      bus.cfg_valid = 1'b0;
      goto_vb();
      tick(2);
      chk("bp_mode_first", bus.mode_q, 0);
      goto_vis();
      pix(200, 40, 1'b1, 12'h00F, "bp_color_first");
      // blink and frame counter wrap
      apply_cfg(2'd3, 12'h0FF);
      pix(100, 50, 1'b1, 12'h0FF, "blink_lo");
      while (fc < 16) frame();
      chk("fcnt_16", bus.frame_cnt, 16);
      pix(100, 50, 1'b1, 12'h000, "blink_hi");
      while (fc < 32) frame();
      pix(100, 50, 1'b1, 12'h0FF, "blink_32");
      while (fc < 256) frame();
      chk("fcnt_wrap", bus.frame_cnt, 8'(fc));
      chk("fcnt_zero", bus.frame_cnt, 0);
      pix(100, 50, 1'b1, 12'h0FF, "blink_wrap");
      // reset during PENDING
      bus.cfg_valid = 1'b1;
      bus.cfg_mode = 2'd1;
      bus.cfg_color = 12'h123;
      tick();
      bus.cfg_valid = 1'b0;
      chk("mr_pending", bus.cfg_pending, 1);
      rst = 1'b1;
      #1;
      chk("mr_pending_clr", bus.cfg_pending, 0);
      chk("mr_ready", bus.cfg_ready, 1);
      chk("mr_fcnt", bus.frame_cnt, 0);
      chk("mr_mode", bus.mode_q, 0);
      chk("mr_rgb", bus.rgb_out, 0);
      tick();
      rst = 1'b0;
      fc = 0;
      tick();
      goto_vb();
      tick(3);
      chk("mr_no_commit", bus.mode_q, 0);
      chk("mr_idle", bus.cfg_pending, 0);
      chk("mr_fcnt_step", bus.frame_cnt, 8'(fc));
      goto_vis();
      pix(10, 10, 1'b1, 12'h000, "mr_black");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
